// File: rtl/inst_fetch.sv
// inst_fetch: PC owner and instruction-memory fetch FSM feeding the IR load path.
// Define FETCH_MISALIGN_CHECK_EN to fault misaligned redirect targets instead of silently aligning them.
module inst_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          TIMEOUT_CYC = 16,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstN,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memGnt,
    input  logic        memRvalid,
    input  logic [31:0] memRdata,
    output logic [31:0] instOut,
    output logic [31:0] pcOut,
    output logic        instValid,
    input  logic        instAccept,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        fetchErr
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;
    state_t state;
    logic [31:0] pc;
    logic [CW-1:0] cnt;
    logic boot;
    logic outstanding;
    logic expired;
    logic misalign;
    logic halt;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign = |redirectPc[1:0];
`else
    assign misalign = 1'b0;
    assign halt = 1'b0;
`endif
    // A granted request whose response has not yet arrived must be drained before refetching.
    assign outstanding = (state == WAIT && !memRvalid) || (state == REQ && memGnt) || state == DROP;
    assign expired = cnt == CW'(TIMEOUT_CYC - 1);
    assign memAddr = {pc[31:2], 2'b00};
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
            pc <= RESET_PC;
            cnt <= '0;
            boot <= 1'b1;
            memReq <= 1'b0;
            instOut <= NOP_INST;
            pcOut <= RESET_PC;
            instValid <= 1'b0;
            fetchErr <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            halt <= 1'b0;
`endif
        end else if (redirect) begin
            pc <= redirectPc & ~32'h3;
            cnt <= '0;
            boot <= 1'b0;
            instValid <= 1'b0;
            fetchErr <= misalign;
            state <= outstanding ? DROP : misalign ? IDLE : REQ;
            memReq <= !outstanding && !misalign;
`ifdef FETCH_MISALIGN_CHECK_EN
            halt <= misalign;
`endif
        end else begin
            case (state)
                IDLE: if (boot) begin
                    boot <= 1'b0;
                    memReq <= 1'b1;
                    state <= REQ;
                end
                REQ: if (memGnt) begin
                    memReq <= 1'b0;
                    cnt <= '0;
                    state <= WAIT;
                end
                WAIT: if (memRvalid) begin
                    instOut <= memRdata;
                    pcOut <= pc;
                    instValid <= 1'b1;
                    pc <= pc + 32'd4;
                    state <= HOLD;
                end else if (expired) begin
                    fetchErr <= 1'b1;
                    state <= IDLE;
                end else
                    cnt <= cnt + 1'b1;
                HOLD: if (instAccept) begin
                    instValid <= 1'b0;
                    memReq <= 1'b1;
                    state <= REQ;
                end
                DROP: if (memRvalid) begin
                    memReq <= !halt;
                    state <= halt ? IDLE : REQ;
                end else if (expired) begin
                    fetchErr <= 1'b1;
                    state <= IDLE;
                end else
                    cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed checks of fetch latency, stalls, redirects, timeouts, wraparound and async reset.
module tb_inst_fetch;
    localparam int T = 16;
    logic        clk = 1'b0;
    logic        rstN;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memGnt;
    logic        memRvalid;
    logic [31:0] memRdata;
    logic [31:0] instOut;
    logic [31:0] pcOut;
    logic        instValid;
    logic        instAccept;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        fetchErr;
    int n_checks = 0;
    int n_fail = 0;
    inst_fetch #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rstN(rstN), .memReq(memReq), .memAddr(memAddr), .memGnt(memGnt),
        .memRvalid(memRvalid), .memRdata(memRdata), .instOut(instOut), .pcOut(pcOut),
        .instValid(instValid), .instAccept(instAccept), .redirect(redirect),
        .redirectPc(redirectPc), .fetchErr(fetchErr)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(negedge clk);
    endtask
    task automatic wait_req();
        int k = 0;
        while (!memReq && k < 40) begin
            cyc();
            k++;
        end
        check("req_seen", 32'(memReq), 32'd1);
    endtask
    task automatic serve(input logic [31:0] d);
        wait_req();
        memGnt = 1'b1;
        cyc();
        memGnt = 1'b0;
        memRvalid = 1'b1;
        memRdata = d;
        cyc();
        memRvalid = 1'b0;
        check("valid", 32'(instValid), 32'd1);
        check("inst", instOut, d);
    endtask
    task automatic accept();
        instAccept = 1'b1;
        cyc();
        instAccept = 1'b0;
    endtask
    task automatic do_redirect(input logic [31:0] a);
        redirect = 1'b1;
        redirectPc = a;
        cyc();
        redirect = 1'b0;
    endtask
    initial begin
        rstN = 1'b0;
        {memGnt, memRvalid, instAccept, redirect} = '0;
        memRdata = '0;
        redirectPc = '0;
        cyc();
        cyc();
        check("rst_req", 32'(memReq), 32'd0);
        check("rst_addr", memAddr, 32'h0);
        check("rst_inst", instOut, 32'h0000_0013);
        check("rst_pc", pcOut, 32'h0);
        check("rst_valid", 32'(instValid), 32'd0);
        check("rst_err", 32'(fetchErr), 32'd0);
        rstN = 1'b1;
        cyc();
        // 1: first fetch after reset
        check("t1_req", 32'(memReq), 32'd1);
        check("t1_addr", memAddr, 32'h0);
        serve(32'h0050_0093);
        check("t1_pc", pcOut, 32'h0);
        accept();
        check("t1_valid_clr", 32'(instValid), 32'd0);
        check("t1_req2", 32'(memReq), 32'd1);
        check("t1_addr2", memAddr, 32'h4);
        // 2: grant stall and accept stall, stray rvalid in HOLD ignored
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t2_req_hold", 32'(memReq), 32'd1);
            check("t2_addr_hold", memAddr, 32'h4);
        end
        serve(32'h1111_1111);
        check("t2_pc", pcOut, 32'h4);
        memRdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            memRvalid = (i == 3);
            cyc();
            check("t2_valid_hold", 32'(instValid), 32'd1);
            check("t2_inst_hold", instOut, 32'h1111_1111);
        end
        memRvalid = 1'b0;
        accept();
        // 3: redirect while WAIT, stale data dropped
        wait_req();
        check("t3_addr", memAddr, 32'h8);
        memGnt = 1'b1;
        cyc();
        memGnt = 1'b0;
        do_redirect(32'h100);
        check("t3_drop_req", 32'(memReq), 32'd0);
        cyc();
        cyc();
        memRvalid = 1'b1;
        memRdata = 32'hDEAD_BEEF;
        cyc();
        memRvalid = 1'b0;
        check("t3_req", 32'(memReq), 32'd1);
        check("t3_addr2", memAddr, 32'h100);
        check("t3_valid", 32'(instValid), 32'd0);
        check("t3_inst", instOut, 32'h1111_1111);
        serve(32'hAAAA_0001);
        check("t3_pc", pcOut, 32'h100);
        accept();
        // 4: response timeout, then recovery by redirect
        wait_req();
        memGnt = 1'b1;
        cyc();
        memGnt = 1'b0;
        for (int i = 0; i < T - 1; i++) cyc();
        check("t4_err_early", 32'(fetchErr), 32'd0);
        cyc();
        check("t4_err", 32'(fetchErr), 32'd1);
        check("t4_req", 32'(memReq), 32'd0);
        for (int i = 0; i < 6; i++) cyc();
        check("t4_req_idle", 32'(memReq), 32'd0);
        check("t4_err_sticky", 32'(fetchErr), 32'd1);
        do_redirect(32'h40);
        check("t4_err_clr", 32'(fetchErr), 32'd0);
        check("t4_addr", memAddr, 32'h40);
        serve(32'h1234_5678);
        check("t4_pc", pcOut, 32'h40);
        accept();
        // 5: PC wraps modulo 2^32
        do_redirect(32'hFFFF_FFFC);
        check("t5_addr", memAddr, 32'hFFFF_FFFC);
        serve(32'h0000_000A);
        check("t5_pc", pcOut, 32'hFFFF_FFFC);
        accept();
        check("t5_addr_wrap", memAddr, 32'h0);
        serve(32'h0000_000B);
        check("t5_pc_wrap", pcOut, 32'h0);
        accept();
        // 6: misaligned redirect target
        do_redirect(32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("t6_err", 32'(fetchErr), 32'd1);
        for (int i = 0; i < 4; i++) cyc();
        check("t6_req", 32'(memReq), 32'd0);
        do_redirect(32'h200);
        check("t6_err_clr", 32'(fetchErr), 32'd0);
        check("t6_addr", memAddr, 32'h200);
`else
        check("t6_err", 32'(fetchErr), 32'd0);
        check("t6_addr", memAddr, 32'h100);
        serve(32'h0000_0C0C);
        check("t6_pc", pcOut, 32'h100);
        accept();
`endif
        // 7: asynchronous reset mid-WAIT
        wait_req();
        memGnt = 1'b1;
        cyc();
        memGnt = 1'b0;
        cyc();
        #2 rstN = 1'b0;
        #1;
        check("t7_req", 32'(memReq), 32'd0);
        check("t7_addr", memAddr, 32'h0);
        check("t7_inst", instOut, 32'h0000_0013);
        check("t7_pc", pcOut, 32'h0);
        check("t7_valid", 32'(instValid), 32'd0);
        check("t7_err", 32'(fetchErr), 32'd0);
        cyc();
        rstN = 1'b1;
        cyc();
        check("t7_restart_req", 32'(memReq), 32'd1);
        check("t7_restart_addr", memAddr, 32'h0);
        serve(32'h0070_0113);
        check("t7_restart_pc", pcOut, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
